cci_mpf_prim_rob_req_tagger: RTL

//  Upstream feeder for the response-sorting ROB. Accepts client read requests, allocates a
//  ROB slot per request, tags the outgoing memory request with the slot index, and writes
//  out-of-order memory responses into the ROB data port by tag.

---
 rtl/cci_mpf_prim_rob_req_tagger.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/cci_mpf_prim_rob_req_tagger.sv
// ROB request tagger: allocates a ROB slot for each client read, tags the
// outgoing memory request with the slot index, and steers out-of-order
// memory responses into the ROB data port by tag.
//
// state          | meaning
// ---------------+-----------------------------------------------------
// req_valid_q    | tagged request held for the memory port
// inflight[t]    | tag t allocated and still awaiting its response
// rsp_valid_q    | response staged for the ROB data write
// err_q          | a response arrived for a tag that was not in flight
module cci_mpf_prim_rob_req_tagger
#(
    parameter int N_ENTRIES       = 32,
    parameter int N_ADDR_BITS     = 42,
    parameter int N_DATA_BITS     = 512,
    parameter int N_META_BITS     = 16,
    parameter int MAX_OUTSTANDING = N_ENTRIES,
    localparam int T              = $clog2(N_ENTRIES)
)
(
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   c_req_valid,
    output logic                   c_req_ready,
    input  logic [N_ADDR_BITS-1:0] c_req_addr,
    input  logic [N_META_BITS-1:0] c_req_meta,

    input  logic                   rob_notFull,
    input  logic [T-1:0]           rob_enqIdx,
    output logic                   rob_enq_en,
    output logic [N_META_BITS-1:0] rob_enqMeta,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [N_ADDR_BITS-1:0] mem_req_addr,
    output logic [T-1:0]           mem_req_tag,

    input  logic                   mem_rsp_valid,
    input  logic [T-1:0]           mem_rsp_tag,
    input  logic [N_DATA_BITS-1:0] mem_rsp_data,

    output logic                   rob_enqData_en,
    output logic [T-1:0]           rob_enqDataIdx,
    output logic [N_DATA_BITS-1:0] rob_enqData,

    output logic [T:0]             outstanding,
    output logic                   err_spurious
);

    localparam logic [31:0] MAX_OUT_32 = MAX_OUTSTANDING;
    localparam logic [T:0]  MAX_OUT    = MAX_OUT_32[T:0];

    logic                   req_valid_q;
    logic [N_ADDR_BITS-1:0] req_addr_q;
    logic [T-1:0]           req_tag_q;

    logic [N_ENTRIES-1:0]   inflight;

    logic                   rsp_valid_q;
    logic [T-1:0]           rsp_tag_q;
    logic [N_DATA_BITS-1:0] rsp_data_q;

    logic                   err_q;
    logic                   can_issue;
    logic                   rsp_hit;

    // The output register may be refilled in the same cycle it drains.
    assign can_issue   = rob_notFull && (outstanding < MAX_OUT) &&
                         (!req_valid_q || mem_req_ready);
    assign c_req_ready = can_issue;
    assign rob_enq_en  = c_req_valid && can_issue;
    assign rob_enqMeta = c_req_meta;

    // Hit is judged against the vector before this cycle's allocation, so a
    // response racing the allocation of its own tag is treated as spurious.
    assign rsp_hit = mem_rsp_valid && inflight[mem_rsp_tag];

    assign mem_req_valid  = req_valid_q;
    assign mem_req_addr   = req_addr_q;
    assign mem_req_tag    = req_tag_q;

    assign rob_enqData_en = rsp_valid_q;
    assign rob_enqDataIdx = rsp_tag_q;
    assign rob_enqData    = rsp_data_q;

    assign err_spurious   = err_q;

    // Request output register: load on allocation, drain when accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_valid_q <= 1'b0;
        end else if (rob_enq_en) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= c_req_addr;
            req_tag_q   <= rob_enqIdx;
        end else if (mem_req_ready) begin
            req_valid_q <= 1'b0;
        end
    end

    // In-flight tag vector; a same-cycle allocation overrides the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= '0;
        end else begin
            if (rsp_hit)
                inflight[mem_rsp_tag] <= 1'b0;
            if (rob_enq_en)
                inflight[rob_enqIdx] <= 1'b1;
        end
    end

    // Response staging register feeding the ROB data port.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_hit;
        end
        rsp_tag_q  <= mem_rsp_tag;
        rsp_data_q <= mem_rsp_data;
    end

    // Sticky flag for responses whose tag is not in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (mem_rsp_valid && !rsp_hit) begin
            err_q <= 1'b1;
        end
    end

    // Count of tags in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else begin
            case ({rob_enq_en, rsp_hit})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    a_enq_not_full: assert property (@(posedge clk) disable iff (reset)
        rob_enq_en |-> rob_notFull);

    a_outstanding_max: assert property (@(posedge clk) disable iff (reset)
        outstanding <= MAX_OUT);

    a_max_range: assert property (@(posedge clk)
        (MAX_OUTSTANDING >= 1) && (MAX_OUTSTANDING <= N_ENTRIES));

    a_entries_pow2: assert property (@(posedge clk)
        (N_ENTRIES > 0) && ((N_ENTRIES & (N_ENTRIES - 1)) == 0));

endmodule
